// File: rtl/pkdet_pkg.sv
// rtl/pkdet_pkg.sv - shared state encoding, default tuning constants and width helper
// for the hpf_peak_detector slice.
package pkdet_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_REFRACT = 2'd2
  } pkdet_state_e;

  localparam int DEF_THR_INIT     = 64;
  localparam int DEF_THR_MIN      = 16;
  localparam int DEF_REFRACT      = 50;
  localparam int DEF_DECAY_PERIOD = 32;

  // Largest value an unsigned counter of width w can hold.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pkdet_ibi_counter.sv
// rtl/pkdet_ibi_counter.sv - saturating, clearable inter-beat sample counter.
module pkdet_ibi_counter
  import pkdet_pkg::*;
#(
  parameter int IBI_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [IBI_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [IBI_W-1:0] CntMax = IBI_W'(sat_max(IBI_W));

  logic [IBI_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + IBI_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == CntMax);

endmodule

// File: rtl/hpf_peak_detector.sv
// rtl/hpf_peak_detector.sv - adaptive-threshold heartbeat peak detector with refractory window.
// Define HPF_PEAK_DETECTOR_PEAK_AMP_EN to add the peak_amp output.
module hpf_peak_detector
  import pkdet_pkg::*;
#(
  parameter int Width        = 10,
  parameter int IBI_W        = 12,
  parameter int THR_INIT     = DEF_THR_INIT,
  parameter int THR_MIN      = DEF_THR_MIN,
  parameter int REFRACT      = DEF_REFRACT,
  parameter int DECAY_PERIOD = DEF_DECAY_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [Width-1:0] x_in,
  output logic                    beat,
  output logic [IBI_W-1:0]        ibi,
  output logic                    ibi_valid,
  output logic signed [Width-1:0] thr
`ifdef HPF_PEAK_DETECTOR_PEAK_AMP_EN
  ,
  output logic signed [Width-1:0] peak_amp
`endif
);

  localparam int DcW = $clog2(DECAY_PERIOD + 1);
  localparam int RcW = $clog2(REFRACT + 1);
  localparam logic signed [Width-1:0] ThrInit = Width'(THR_INIT);
  localparam logic signed [Width-1:0] ThrMin  = Width'(THR_MIN);
  localparam logic [IBI_W-1:0]        IbiMax  = IBI_W'(sat_max(IBI_W));

  pkdet_state_e            state_q, state_d;
  logic signed [Width-1:0] peak_q, peak_d;
  logic signed [Width-1:0] thr_q, thr_d;
  logic [DcW-1:0]          dec_q, dec_d;
  logic [RcW-1:0]          rc_q, rc_d;
  logic                    first_q, first_d;
  logic                    beat_q, beat_d;
  logic [IBI_W-1:0]        ibi_q, ibi_d;
  logic                    ibi_valid_q, ibi_valid_d;
  logic signed [Width-1:0] pamp_q, pamp_d;

  logic                    trigger;
  logic [IBI_W-1:0]        cnt;
  logic                    cnt_sat;
  logic [IBI_W-1:0]        ibi_next;
  logic signed [Width-1:0] peak_half;

  assign trigger   = en && (state_q == ST_TRACK) && (x_in <= thr_q);
  assign peak_half = peak_q >>> 1;
  // A count that already sits at, or would step onto, the ceiling reports the ceiling.
  assign ibi_next  = cnt_sat ? IbiMax : cnt + IBI_W'(1);

  pkdet_ibi_counter #(
    .IBI_W(IBI_W)
  ) u_ibi_counter (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (en),
    .clr_i(trigger),
    .cnt_o(cnt),
    .sat_o(cnt_sat)
  );

  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    thr_d       = thr_q;
    dec_d       = dec_q;
    rc_d        = rc_q;
    first_d     = first_q;
    beat_d      = 1'b0;
    ibi_d       = ibi_q;
    ibi_valid_d = 1'b0;
    pamp_d      = pamp_q;
    if (en) begin
      case (state_q)
        ST_SEARCH: begin
          if (x_in > thr_q) begin
            state_d = ST_TRACK;
            peak_d  = x_in;
          end else if (dec_q == DcW'(DECAY_PERIOD - 1)) begin
            dec_d = '0;
            if (thr_q > ThrMin) thr_d = thr_q - Width'(1);
          end else begin
            dec_d = dec_q + DcW'(1);
          end
        end
        ST_TRACK: begin
          if (x_in > peak_q) peak_d = x_in;
          if (x_in <= thr_q) begin
            beat_d      = 1'b1;
            ibi_d       = ibi_next;
            ibi_valid_d = !first_q && (ibi_next != IbiMax);
            first_d     = 1'b0;
            thr_d       = (peak_half > ThrMin) ? peak_half : ThrMin;
            pamp_d      = peak_q;
            rc_d        = '0;
            state_d     = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          if (rc_q == RcW'(REFRACT - 1)) begin
            state_d = ST_SEARCH;
            dec_d   = '0;
          end else begin
            rc_d = rc_q + RcW'(1);
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      peak_q      <= '0;
      thr_q       <= ThrInit;
      dec_q       <= '0;
      rc_q        <= '0;
      first_q     <= 1'b1;
      beat_q      <= 1'b0;
      ibi_q       <= '0;
      ibi_valid_q <= 1'b0;
      pamp_q      <= '0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      thr_q       <= thr_d;
      dec_q       <= dec_d;
      rc_q        <= rc_d;
      first_q     <= first_d;
      beat_q      <= beat_d;
      ibi_q       <= ibi_d;
      ibi_valid_q <= ibi_valid_d;
      pamp_q      <= pamp_d;
    end
  end

  assign beat      = beat_q;
  assign ibi       = ibi_q;
  assign ibi_valid = ibi_valid_q;
  assign thr       = thr_q;
`ifdef HPF_PEAK_DETECTOR_PEAK_AMP_EN
  assign peak_amp  = pamp_q;
`endif

endmodule
